timer_counter_unit: RTL and testbench

Parametrised successor to the project's single timer/counter circuit. Each instance is one timer/counter channel with timer or counter select, gate/intx qualification, three count modes (wrap, auto-reload, one-shot), a software load, a sticky overflow flag and a one-cycle overflow pulse on y. It sits beside the project top and is instantiated once per channel.

---
 rtl/timer_counter_unit.sv | 122 ++++++++++++
 tb/tb_timer_counter_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_unit.sv
// One timer/counter channel: timer/counter select, gate/intx qualification, wrap/auto-reload/one-shot modes.
// Optional clock prescaler for timer mode is enabled by defining TCU_PRESCALER_EN.
module timer_counter_unit #(
  parameter int WIDTH        = 16,
  parameter int PRESCALE_DIV = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer,
  input  logic             timer_run,
  input  logic             gate,
  input  logic             intx,
  input  logic             select,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] reload_value,
  input  logic             tf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tf,
  output logic             y,
  output logic             armed
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             r_timer_s1, r_timer_s2, r_timer_s3;
  logic             r_intx_s1, r_intx_s2;
  logic             r_tr_prev;
  logic [WIDTH-1:0] r_count;
  logic             r_tf, r_y, r_armed;

  logic w_fall, w_run_ok, w_timer_tick, w_tick, w_ovf, w_rearm;

  // s3 is always updated, so the edge history stays current in both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer_s1 <= 1'b0;
      r_timer_s2 <= 1'b0;
      r_timer_s3 <= 1'b0;
      r_intx_s1  <= 1'b0;
      r_intx_s2  <= 1'b0;
      r_tr_prev  <= 1'b0;
    end else begin
      r_timer_s1 <= timer;
      r_timer_s2 <= r_timer_s1;
      r_timer_s3 <= r_timer_s2;
      r_intx_s1  <= intx;
      r_intx_s2  <= r_intx_s1;
      r_tr_prev  <= timer_run;
    end
  end

  assign w_fall   = r_timer_s3 & ~r_timer_s2;
  assign w_run_ok = timer_run & (~gate | r_intx_s2) & (r_armed | (mode != 2'b10));
  assign w_rearm  = timer_run & ~r_tr_prev;

`ifdef TCU_PRESCALER_EN
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PW-1:0] r_presc;

  assign w_timer_tick = (r_presc == PW'(PRESCALE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (load) begin
      r_presc <= '0;
    end else if (w_run_ok && !select) begin
      r_presc <= w_timer_tick ? '0 : r_presc + PW'(1);
    end
  end
`else
  assign w_timer_tick = 1'b1;
`endif

  assign w_tick = w_run_ok & (select ? w_fall : w_timer_tick);
  assign w_ovf  = w_tick & (r_count == ALL_ONES) & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tf    <= 1'b0;
      r_y     <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_y <= w_ovf;
      if (w_ovf) begin
        r_tf <= 1'b1;
      end else if (tf_clr) begin
        r_tf <= 1'b0;
      end
      // A 0->1 on timer_run re-arms; a one-shot overflow in the same cycle still disarms.
      if (w_rearm) begin
        r_armed <= 1'b1;
      end
      if (load) begin
        r_count <= load_value;
        r_armed <= 1'b1;
      end else if (w_tick) begin
        if (r_count != ALL_ONES) begin
          r_count <= r_count + WIDTH'(1);
        end else begin
          case (mode)
            2'b01:   r_count <= reload_value;
            2'b10: begin
              r_count <= '0;
              r_armed <= 1'b0;
            end
            default: r_count <= '0;
          endcase
        end
      end
    end
  end

  assign count = r_count;
  assign tf    = r_tf;
  assign y     = r_y;
  assign armed = r_armed;

endmodule

// File: tb/tb_timer_counter_unit.sv
// Scoreboard bench for timer_counter_unit (WIDTH=8): stimulus queues expected outputs, a monitor compares on the falling edge.
module tb_timer_counter_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         timer, timer_run, gate, intx, select, load, tf_clr;
  logic [1:0]   mode;
  logic [W-1:0] load_value, reload_value;
  logic [W-1:0] count;
  logic         tf, y, armed;

  typedef struct {
    string        name;
    logic [W-1:0] c;
    logic         tf;
    logic         y;
    logic         armed;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  timer_counter_unit #(.WIDTH(W), .PRESCALE_DIV(12)) dut (
    .clk(clk), .rst_n(rst_n), .timer(timer), .timer_run(timer_run),
    .gate(gate), .intx(intx), .select(select), .mode(mode), .load(load),
    .load_value(load_value), .reload_value(reload_value), .tf_clr(tf_clr),
    .count(count), .tf(tf), .y(y), .armed(armed)
  );

  always #5 clk = ~clk;

  // Every record queued since the last falling edge describes the present output state.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (count !== e.c || tf !== e.tf || y !== e.y || armed !== e.armed) begin
        n_bad++;
        $display("FAIL %s: got count=%h tf=%b y=%b armed=%b, expected count=%h tf=%b y=%b armed=%b",
                 e.name, count, tf, y, armed, e.c, e.tf, e.y, e.armed);
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL watchdog: got no end of stimulus, expected completion");
      $fatal(1, "timeout");
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_o(input string name, input logic [W-1:0] c, input logic t,
                          input logic yy, input logic a);
    exp_t e;
    e.name = name; e.c = c; e.tf = t; e.y = yy; e.armed = a;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; timer = 1'b1; timer_run = 1'b0; gate = 1'b0; intx = 1'b0;
    select = 1'b0; mode = 2'b00; load = 1'b0; tf_clr = 1'b0;
    load_value = '0; reload_value = '0;
    step(3);
    expect_o("reset", 8'h00, 0, 0, 1);
    step(1);
    rst_n = 1'b1; timer_run = 1'b1;

`ifdef TCU_PRESCALER_EN
    step(11);
    expect_o("presc_11clk", 8'h00, 0, 0, 1);
    step(1);
    expect_o("presc_12clk", 8'h01, 0, 0, 1);
    step(11);
    expect_o("presc_23clk", 8'h01, 0, 0, 1);
    step(1);
    expect_o("presc_24clk", 8'h02, 0, 0, 1);
    timer_run = 1'b0;
    step(20);
    expect_o("presc_freeze", 8'h02, 0, 0, 1);
    timer_run = 1'b1;
    step(12);
    expect_o("presc_resume", 8'h03, 0, 0, 1);
`else
    // wrap mode from reset
    step(255);
    expect_o("wrap_255", 8'hFF, 0, 0, 1);
    step(1);
    expect_o("wrap_ovf", 8'h00, 1, 1, 1);
    step(1);
    expect_o("wrap_after", 8'h01, 1, 0, 1);
    tf_clr = 1'b1;
    step(1);
    expect_o("tf_clr", 8'h02, 0, 0, 1);
    tf_clr = 1'b0;

    // auto-reload
    mode = 2'b01; reload_value = 8'hF0; load = 1'b1; load_value = 8'hFE;
    step(1);
    expect_o("reload_load", 8'hFE, 0, 0, 1);
    load = 1'b0;
    step(1);
    expect_o("reload_ff", 8'hFF, 0, 0, 1);
    step(1);
    expect_o("reload_ovf1", 8'hF0, 1, 1, 1);
    step(15);
    expect_o("reload_ff2", 8'hFF, 1, 0, 1);
    step(1);
    expect_o("reload_ovf2", 8'hF0, 1, 1, 1);

    // one-shot
    mode = 2'b10; load = 1'b1; load_value = 8'hFD;
    step(1);
    expect_o("oneshot_load", 8'hFD, 1, 0, 1);
    load = 1'b0;
    step(2);
    expect_o("oneshot_ff", 8'hFF, 1, 0, 1);
    step(1);
    expect_o("oneshot_ovf", 8'h00, 1, 1, 0);
    step(20);
    expect_o("oneshot_frozen", 8'h00, 1, 0, 0);
    timer_run = 1'b0;
    step(1);
    timer_run = 1'b1;
    step(1);
    expect_o("oneshot_rearm", 8'h00, 1, 0, 1);
    step(1);
    expect_o("oneshot_resume", 8'h01, 1, 0, 1);
    mode = 2'b00;
`endif

    // counter mode: 6 falling edges, 5 low / 5 high
    select = 1'b1; load = 1'b1; load_value = 8'h00;
    step(1);
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      timer = 1'b0;
      step(2);
      expect_o($sformatf("cnt_wait%0d", i), W'(i), tf, 0, 1);
      step(1);
      expect_o($sformatf("cnt_edge%0d", i), W'(i + 1), tf, 0, 1);
      step(2);
      timer = 1'b1;
      step(5);
    end
    expect_o("cnt_total", 8'h06, tf, 0, 1);
    select = 1'b0;

`ifndef TCU_PRESCALER_EN
    // gate/intx qualification
    gate = 1'b1; intx = 1'b0; load = 1'b1; load_value = 8'h10;
    step(1);
    load = 1'b0;
    step(3);
    expect_o("gate_frozen", 8'h10, 1, 0, 1);
    intx = 1'b1;
    step(2);
    expect_o("gate_sync_delay", 8'h10, 1, 0, 1);
    step(1);
    expect_o("gate_resume", 8'h11, 1, 0, 1);
    gate = 1'b0;

    // overflow coincident with tf_clr
    load = 1'b1; load_value = 8'hFE; tf_clr = 1'b1;
    step(1);
    expect_o("clr_on_load", 8'hFE, 0, 0, 1);
    load = 1'b0;
    step(1);
    tf_clr = 1'b1;
    step(1);
    expect_o("ovf_vs_clr", 8'h00, 1, 1, 1);
    tf_clr = 1'b0;

    // load coincident with overflow
    load = 1'b1; load_value = 8'hFF;
    step(1);
    load_value = 8'h33;
    step(1);
    expect_o("load_vs_ovf", 8'h33, 1, 0, 1);
    load = 1'b0;

    // timer_run drop freezes
    timer_run = 1'b0;
    step(3);
    expect_o("run_freeze", 8'h33, 1, 0, 1);
    timer_run = 1'b1;
    step(1);
    expect_o("run_resume", 8'h34, 1, 0, 1);
`endif

    // asynchronous reset mid-count
    step(5);
    rst_n = 1'b0;
    #1;
    expect_o("async_reset", 8'h00, 0, 0, 1);
    step(1);
    rst_n = 1'b1;
    step(2);
    done = 1'b1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
